// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit.
// Holds the architectural HI/LO registers, computes mult/multu/div/divu into a
// pending pair at start, and commits the pending pair when the busy
// down-counter reaches terminal count.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDU_op,
    input  logic        E_MDU_start,
    input  logic [31:0] E_ReadData_rs,
    input  logic [31:0] E_ReadData_rt,
    output logic        E_MDU_busy,
    output logic [31:0] E_MDU_out,
    output logic [31:0] E_MDU_HI,
    output logic [31:0] E_MDU_LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic [3:0]  r_cnt;

    logic               w_idle;
    logic               w_rt_zero;
    logic               w_div_ovf;
    logic [31:0]        w_divisor;
    logic signed [63:0] w_smul;
    logic [63:0]        w_umul;
    logic signed [31:0] w_squo;
    logic signed [31:0] w_srem;
    logic [31:0]        w_uquo;
    logic [31:0]        w_urem;

    assign w_idle    = (r_cnt == 4'd0);
    assign w_rt_zero = (E_ReadData_rt == 32'd0);
    assign w_div_ovf = (E_ReadData_rs == 32'h8000_0000) && (E_ReadData_rt == 32'hFFFF_FFFF);
    // A zero divisor is replaced by 1 so the dividers never see x/0; the
    // result is discarded in that case anyway.
    assign w_divisor = w_rt_zero ? 32'd1 : E_ReadData_rt;

    assign w_smul = $signed({{32{E_ReadData_rs[31]}}, E_ReadData_rs})
                  * $signed({{32{E_ReadData_rt[31]}}, E_ReadData_rt});
    assign w_umul = {32'd0, E_ReadData_rs} * {32'd0, E_ReadData_rt};
    assign w_squo = $signed(E_ReadData_rs) / $signed(w_divisor);
    assign w_srem = $signed(E_ReadData_rs) % $signed(w_divisor);
    assign w_uquo = E_ReadData_rs / w_divisor;
    assign w_urem = E_ReadData_rs % w_divisor;

    // HI/LO, pending result and busy down-counter; new work only when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_cnt     <= 4'd0;
        end else if (!w_idle) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else if (E_MDU_start) begin
            case (E_MDU_op)
                OP_MULT: begin
                    {r_pend_hi, r_pend_lo} <= w_smul;
                    r_cnt <= MULT_LOAD;
                end
                OP_MULTU: begin
                    {r_pend_hi, r_pend_lo} <= w_umul;
                    r_cnt <= MULT_LOAD;
                end
                OP_DIV: begin
                    if (w_rt_zero) begin
                        r_pend_hi <= r_hi;
                        r_pend_lo <= r_lo;
                    end else if (w_div_ovf) begin
                        r_pend_hi <= 32'd0;
                        r_pend_lo <= 32'h8000_0000;
                    end else begin
                        r_pend_hi <= w_srem;
                        r_pend_lo <= w_squo;
                    end
                    r_cnt <= DIV_LOAD;
                end
                OP_DIVU: begin
                    if (w_rt_zero) begin
                        r_pend_hi <= r_hi;
                        r_pend_lo <= r_lo;
                    end else begin
                        r_pend_hi <= w_urem;
                        r_pend_lo <= w_uquo;
                    end
                    r_cnt <= DIV_LOAD;
                end
                default: ;
            endcase
        end else if (E_MDU_op == OP_MTHI) begin
            r_hi <= E_ReadData_rs;
        end else if (E_MDU_op == OP_MTLO) begin
            r_lo <= E_ReadData_rs;
        end
    end

    // mfhi/mflo read path, zero for every other op.
    always_comb begin
        E_MDU_out = 32'd0;
        case (E_MDU_op)
            OP_MFHI: E_MDU_out = r_hi;
            OP_MFLO: E_MDU_out = r_lo;
            default: ;
        endcase
    end

    assign E_MDU_busy = !w_idle;
    assign E_MDU_HI   = r_hi;
    assign E_MDU_LO   = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: reset, mult/div results and busy length,
// divide-by-zero, overflow, ignore-while-busy and mfhi/mflo/mthi/mtlo.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic [3:0]  E_MDU_op;
    logic        E_MDU_start;
    logic [31:0] E_ReadData_rs;
    logic [31:0] E_ReadData_rt;
    logic        E_MDU_busy;
    logic [31:0] E_MDU_out;
    logic [31:0] E_MDU_HI;
    logic [31:0] E_MDU_LO;

    int n_total  = 0;
    int n_passed = 0;
    int cyc;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .E_MDU_op     (E_MDU_op),
        .E_MDU_start  (E_MDU_start),
        .E_ReadData_rs(E_ReadData_rs),
        .E_ReadData_rt(E_ReadData_rt),
        .E_MDU_busy   (E_MDU_busy),
        .E_MDU_out    (E_MDU_out),
        .E_MDU_HI     (E_MDU_HI),
        .E_MDU_LO     (E_MDU_LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Issue a start at the current negedge, then count busy cycles (bounded).
    task automatic run_op(input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, output int cycles);
        E_MDU_op = op; E_MDU_start = 1'b1; E_ReadData_rs = rs; E_ReadData_rt = rt;
        @(negedge clk);
        E_MDU_start = 1'b0; E_MDU_op = 4'd0;
        cycles = 0;
        while (E_MDU_busy === 1'b1 && cycles < 30) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] rs);
        E_MDU_op = op; E_ReadData_rs = rs;
        @(negedge clk);
        E_MDU_op = 4'd0;
    endtask

    initial begin
        reset = 1'b0; E_MDU_op = 4'd0; E_MDU_start = 1'b0;
        E_ReadData_rs = 32'd0; E_ReadData_rt = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, E_MDU_busy}, 32'd0);
        chk("rst_hi", E_MDU_HI, 32'd0);
        chk("rst_lo", E_MDU_LO, 32'd0);
        chk("rst_out", E_MDU_out, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Reset in the middle of a divide.
        move_to(4'd7, 32'h55);
        chk("mthi_55", E_MDU_HI, 32'h55);
        E_MDU_op = 4'd3; E_MDU_start = 1'b1; E_ReadData_rs = 32'd100; E_ReadData_rt = 32'd7;
        @(negedge clk);
        E_MDU_op = 4'd0; E_MDU_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("middiv_busy", {31'd0, E_MDU_busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, E_MDU_busy}, 32'd0);
        chk("midrst_hi", E_MDU_HI, 32'd0);
        chk("midrst_lo", E_MDU_LO, 32'd0);
        @(negedge clk);
        reset = 1'b1; E_MDU_op = 4'd5;
        #1;
        chk("midrst_mfhi", E_MDU_out, 32'd0);
        repeat (12) @(negedge clk);
        E_MDU_op = 4'd0;
        chk("discard_busy", {31'd0, E_MDU_busy}, 32'd0);
        chk("discard_hi", E_MDU_HI, 32'd0);
        chk("discard_lo", E_MDU_LO, 32'd0);

        // mult / multu
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, cyc);
        chk("mult_cycles", cyc, 32'd5);
        chk("mult_hi", E_MDU_HI, 32'hFFFF_FFFF);
        chk("mult_lo", E_MDU_LO, 32'hFFFF_FFFA);
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3, cyc);
        chk("multu_cycles", cyc, 32'd5);
        chk("multu_hi", E_MDU_HI, 32'h0000_0002);
        chk("multu_lo", E_MDU_LO, 32'hFFFF_FFFA);

        // div / divu
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, cyc);
        chk("div_cycles", cyc, 32'd10);
        chk("div_lo", E_MDU_LO, 32'hFFFF_FFFD);
        chk("div_hi", E_MDU_HI, 32'hFFFF_FFFF);
        run_op(4'd4, 32'd7, 32'd2, cyc);
        chk("divu_cycles", cyc, 32'd10);
        chk("divu_lo", E_MDU_LO, 32'd3);
        chk("divu_hi", E_MDU_HI, 32'd1);

        // Divide by zero keeps HI/LO
        move_to(4'd7, 32'h11);
        move_to(4'd8, 32'h22);
        chk("mtlo_22", E_MDU_LO, 32'h22);
        run_op(4'd4, 32'd5, 32'd0, cyc);
        chk("div0_cycles", cyc, 32'd10);
        chk("div0_hi", E_MDU_HI, 32'h11);
        chk("div0_lo", E_MDU_LO, 32'h22);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        chk("ovf_lo", E_MDU_LO, 32'h8000_0000);
        chk("ovf_hi", E_MDU_HI, 32'd0);

        // Ignore while busy: mult 2x3, disturbances on busy cycles 2..5
        E_MDU_op = 4'd1; E_MDU_start = 1'b1; E_ReadData_rs = 32'd2; E_ReadData_rt = 32'd3;
        @(negedge clk);
        E_MDU_op = 4'd0; E_MDU_start = 1'b0;
        @(negedge clk);
        E_MDU_op = 4'd8; E_ReadData_rs = 32'hAA;
        @(negedge clk);
        E_MDU_op = 4'd1; E_MDU_start = 1'b1; E_ReadData_rs = 32'd7; E_ReadData_rt = 32'd7;
        @(negedge clk);
        E_MDU_op = 4'd8; E_MDU_start = 1'b0; E_ReadData_rs = 32'hAA;
        @(negedge clk);
        E_MDU_op = 4'd1; E_MDU_start = 1'b1; E_ReadData_rs = 32'd7; E_ReadData_rt = 32'd7;
        chk("ign_busy_c5", {31'd0, E_MDU_busy}, 32'd1);
        @(negedge clk);
        E_MDU_op = 4'd0; E_MDU_start = 1'b0;
        chk("ign_busy_after", {31'd0, E_MDU_busy}, 32'd0);
        chk("ign_lo", E_MDU_LO, 32'd6);
        chk("ign_hi", E_MDU_HI, 32'd0);
        run_op(4'd1, 32'd7, 32'd7, cyc);
        chk("restart_cycles", cyc, 32'd5);
        chk("restart_lo", E_MDU_LO, 32'd49);

        // mthi then immediate mfhi; mflo; none
        E_MDU_op = 4'd7; E_ReadData_rs = 32'h1234;
        @(negedge clk);
        E_MDU_op = 4'd5;
        #1;
        chk("mfhi_1234", E_MDU_out, 32'h1234);
        E_MDU_op = 4'd6;
        #1;
        chk("mflo", E_MDU_out, 32'd49);
        E_MDU_op = 4'd0;
        #1;
        chk("op_none", E_MDU_out, 32'd0);
        E_MDU_op = 4'd9;
        #1;
        chk("op_9", E_MDU_out, 32'd0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
